// File: rtl/qdrc_arb_pkg.sv
// rtl/qdrc_arb_pkg.sv - shared types and constants for the two-port QDR arbiter
package qdrc_arb_pkg;

  localparam int NUM_PORTS      = 2;
  localparam int DEF_RD_LATENCY = 9;

  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } tag_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_id_t p);
    port_onehot    = '0;
    port_onehot[p] = 1'b1;
  endfunction

endpackage

// File: rtl/qdrc_arbiter_if.sv
// rtl/qdrc_arbiter_if.sv - requester-side bus of the QDR arbiter (both ports packed)
interface qdrc_arbiter_if
  import qdrc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 21
);

  logic [NUM_PORTS-1:0]              req;
  logic [NUM_PORTS-1:0]              we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr;
  logic [NUM_PORTS*2*DATA_WIDTH-1:0] wr_data;
  logic [NUM_PORTS-1:0]              ack;
  logic [2*DATA_WIDTH-1:0]           rd_data;
  logic [NUM_PORTS-1:0]              rd_dvld;

  modport master (
    output req, we, addr, wr_data,
    input  ack, rd_data, rd_dvld
  );

  modport slave (
    input  req, we, addr, wr_data,
    output ack, rd_data, rd_dvld
  );

endinterface

// File: rtl/qdrc_arb_tag_pipe.sv
// rtl/qdrc_arb_tag_pipe.sv - RD_LATENCY-deep {valid, port} shift register that
// steers each read return to the port that issued it.
module qdrc_arb_tag_pipe
  import qdrc_arb_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                 clk0,
  input  logic                 reset_n,
  input  logic                 push_valid,
  input  port_id_t             push_port,
  output logic [NUM_PORTS-1:0] dvld
);

  tag_t [RD_LATENCY-1:0] stage_q;
  tag_t [RD_LATENCY-1:0] stage_d;

  always_comb begin
    stage_d[0].valid = push_valid;
    stage_d[0].port  = push_port;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset clears every stage so reads in flight at reset never return.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dvld = stage_q[RD_LATENCY-1].valid ? port_onehot(stage_q[RD_LATENCY-1].port) : '0;

endmodule

// File: rtl/qdrc_arbiter.sv
// rtl/qdrc_arbiter.sv - two-port round-robin arbiter in front of a QDR controller user port.
// QDRC_ARB_FIXED_PRIO_EN: when defined, port 0 always wins contention (no last-grant pointer).
module qdrc_arbiter
  import qdrc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 21,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                    clk0,
  input  logic                    reset_n,
  input  logic                    phy_rdy,
  qdrc_arbiter_if.slave           bus,
  output logic                    usr_rd_strb,
  output logic                    usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data
);

  localparam int WORD_W = 2*DATA_WIDTH;

  port_id_t             sel;
  logic [NUM_PORTS-1:0] ack;
  logic                 xfer;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [WORD_W-1:0]    grant_wdata;

  logic                  rd_strb_q, rd_strb_d;
  logic                  wr_strb_q, wr_strb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  port_id_t              owner_q, owner_d;

`ifdef QDRC_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = ~bus.req[0];
  end
`else
  port_id_t last_q, last_d;

  // Under contention the port not granted most recently wins.
  always_comb begin
    if (&bus.req) begin
      sel = ~last_q;
    end else begin
      sel = bus.req[1];
    end
    last_d = xfer ? sel : last_q;
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // ack sees only req, phy_rdy and registered state; reset_n keeps it quiet during reset.
  always_comb begin
    if (reset_n && phy_rdy) begin
      ack = bus.req & port_onehot(sel);
    end else begin
      ack = '0;
    end
    xfer = |ack;
  end

  assign grant_addr  = sel ? bus.addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.addr[ADDR_WIDTH-1:0];
  assign grant_wdata = sel ? bus.wr_data[2*WORD_W-1:WORD_W]      : bus.wr_data[WORD_W-1:0];

  always_comb begin
    rd_strb_d = 1'b0;
    wr_strb_d = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    if (xfer) begin
      rd_strb_d = ~bus.we[sel];
      wr_strb_d = bus.we[sel];
      addr_d    = grant_addr;
      wdata_d   = grant_wdata;
      owner_d   = sel;
    end
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      rd_strb_q <= 1'b0;
      wr_strb_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= 1'b0;
    end else begin
      rd_strb_q <= rd_strb_d;
      wr_strb_q <= wr_strb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
    end
  end

  qdrc_arb_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tag_pipe (
    .clk0       (clk0),
    .reset_n    (reset_n),
    .push_valid (rd_strb_q),
    .push_port  (owner_q),
    .dvld       (bus.rd_dvld)
  );

  assign bus.ack      = ack;
  assign bus.rd_data  = usr_rd_data;
  assign usr_rd_strb  = rd_strb_q;
  assign usr_wr_strb  = wr_strb_q;
  assign usr_addr     = addr_q;
  assign usr_wr_data  = wdata_q;

endmodule

// File: doc/qdrc_arbiter.md
# qdrc_arbiter

Two-port arbiter that shares one QDR controller user interface between two independent requesters. Sits between the requesters and the controller's strobe/address/data ports, issues at most one command per clk0 cycle, and routes each read return to the requester that issued it. Commands are held off until the PHY reports ready.

## Interface
- DATA_WIDTH, 36: QDR data width; user words are 2*DATA_WIDTH.
- ADDR_WIDTH, 21: QDR burst address width.
- RD_LATENCY, 9: clk0 cycles from usr_rd_strb high to the matching usr_rd_data being valid; minimum 2.
- clk0  input  1  the only clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- phy_rdy  input  1  controller calibrated; commands are accepted only while it is high.
- req  input  2  per-port command request; bit p belongs to port p.
- we  input  2  per-port operation select: 1 = write, 0 = read.
- addr  input  2*ADDR_WIDTH  per-port address; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  input  4*DATA_WIDTH  per-port write word; slice [p*2*DATA_WIDTH +: 2*DATA_WIDTH].
- ack  output  2  per-port accept; combinational.
- rd_data  output  2*DATA_WIDTH  read return data, broadcast to both ports.
- rd_dvld  output  2  per-port read-data valid.
- usr_rd_strb  output  1  read command to the controller.
- usr_wr_strb  output  1  write command to the controller.
- usr_addr  output  ADDR_WIDTH  command address to the controller.
- usr_wr_data  output  2*DATA_WIDTH  write word to the controller.
- usr_rd_data  input  2*DATA_WIDTH  read data from the controller.

## Operation
- **Handshake (valid/ready).** A port transfers on the clk0 edge where req[p] and ack[p] are both high.
  - The port holds we, addr and wr_data stable while req[p] is high and ack[p] is low.
  - ack is never high for both ports in the same cycle.
  - ack[p] = phy_rdy & req[p] & (port p selected).
- **Selection: round-robin.**
  - Only one port requesting: that port is selected.
  - Both ports requesting: the port not granted most recently is selected.
  - The last-grant pointer updates only on a transfer.
  - Pointer reset value is 1, so port 0 wins the first contention.
- **Command register.** On a transfer:
  - usr_addr and usr_wr_data load from the granted slice.
  - usr_wr_strb is set to we[p]; usr_rd_strb is set to ~we[p].
  - With no transfer, both strobes are 0 and usr_addr/usr_wr_data hold their values.
- **Read tag pipe.** RD_LATENCY stages, each holding {valid, port}.
  - Stage 0 loads {usr_rd_strb, owner of the registered command}.
  - At the last stage, rd_dvld[owner] = valid.
  - rd_data = usr_rd_data, combinational passthrough.
- **phy_rdy low.**
  - No new acks are given.
  - Already-issued reads still complete through the tag pipe.
- **Reset values.** All of the following are 0: ack, rd_dvld, usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data, all tag stages. rd_data follows usr_rd_data.
- **Reset mid-operation.** Outstanding reads are discarded: no rd_dvld fires for reads issued before reset.

## Timing
- A transfer at edge t drives the command outputs at t (valid in cycle t..t+1). The strobe lasts exactly one cycle unless another transfer follows.
- Back-to-back transfers are allowed every cycle, giving 100% command throughput.
- Read issued at edge t: rd_dvld[p] is high for exactly one cycle, starting at edge t+RD_LATENCY.
- Read returns arrive in issue order; no reordering.
- Both ports requesting continuously: grants alternate 0,1,0,1…
- ack depends combinationally on req and phy_rdy, and on registered state only. There is no combinational path from any usr_* input to ack.

## Configuration
- QDRC_ARB_FIXED_PRIO_EN
  - **Defined:** port 0 always wins contention. The last-grant pointer is removed; port 1 is served only in cycles where req[0] is low.
  - **Undefined:** round-robin as specified above.

## Structure
- **Package qdrc_arb_pkg:**
  - NUM_PORTS = 2.
  - Port-id type (1 bit).
  - Tag-entry struct {valid, port}.
  - Default RD_LATENCY = 9.
- **One sub-module, qdrc_arb_tag_pipe:**
  - Parameterised RD_LATENCY-deep shift register of tag entries.
  - Inputs: push valid and port id.
  - Outputs: the one-hot per-port dvld.
- The top level holds the selection logic, last-grant pointer and command register.

## Test plan
- **Reset and idle:** hold reset_n low, drive req=2'b11 → ack, both strobes and rd_dvld stay 0. Release reset_n with phy_rdy=0 → ack stays 0.
- **Single write:** port 1, we=1, addr=21'h1ABCD, wr_data=72'hA5…, phy_rdy=1 → ack[1] high for one cycle; next cycle usr_wr_strb=1, usr_addr=21'h1ABCD, usr_rd_strb=0.
- **Contention:** both ports hold req=1 for 6 cycles → grant sequence 0,1,0,1,0,1 with no idle cycle. With QDRC_ARB_FIXED_PRIO_EN defined → 0,0,0,0,0,0.
- **Read routing:** port 0 reads at edge t and port 1 reads at edge t+1; model returns usr_rd_data=D0 then D1 → rd_dvld=2'b01 at t+9 with rd_data=D0, then rd_dvld=2'b10 at t+10 with rd_data=D1.
- **phy_rdy drop:** issue a read, then drop phy_rdy the next cycle while req stays high → no further ack; rd_dvld for the issued read still fires 9 cycles after it was issued.
- **Reset mid-read:** issue 3 reads, assert reset_n low at cycle 4 for one cycle → no rd_dvld for those reads; the first post-reset contention grants port 0.
